data_mem_responder: RTL and testbench

Memory-mapped data-side responder for the pipelined RV32 core: it answers the core's memory-stage load/store requests (WE/RE/A/WD → RD) from the response side of that interface. It provides a word RAM, a free-running cycle counter, a scratch register and an 8-bit output FIFO with its own drain handshake. A Busy line asks the core to hold the memory stage when a store hits a full FIFO.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/byte_fifo.sv | 67 ++++++
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder.
//   - Byte offsets of the four registers in the MMIO window.
//   - Bit positions of the fields in the STATUS register.
//   - Address-region enum and the decode helper used by the top.
package dmem_pkg;

   // Register byte offsets inside the 16-byte MMIO window
   localparam logic [3:0] OFF_COUNT   = 4'h0;
   localparam logic [3:0] OFF_TXDATA  = 4'h4;
   localparam logic [3:0] OFF_STATUS  = 4'h8;
   localparam logic [3:0] OFF_SCRATCH = 4'hC;

   // STATUS layout: bit0 full, bit1 empty, bits[7:4] occupancy
   localparam int unsigned ST_FULL_BIT  = 0;
   localparam int unsigned ST_EMPTY_BIT = 1;
   localparam int unsigned ST_OCC_LSB   = 4;
   localparam int unsigned ST_OCC_W     = 4;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } region_e;

   // Full-address compare, so the window boundaries are exact byte bounds
   function automatic region_e decode_region(logic [31:0] addr, logic [31:0] ram_bytes,
                                             logic [31:0] mmio_base);
      if (addr < ram_bytes) begin
         return REG_RAM;
      end else if (addr >= mmio_base && addr < mmio_base + 32'd16) begin
         return REG_MMIO;
      end
      return REG_NONE;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     enqueue request and byte (ignored when full)
//   pop_i              dequeue request (ignored when empty)
//   full_o, empty_o    flags derived from the registered occupancy
//   count_o            occupancy 0..DEPTH
//   head_o             oldest entry, 0 when empty
module byte_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic [7:0]      data_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o,
   output logic [7:0]      head_o
);

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         mem_q   <= '{default: 8'h00};
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (do_push) mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the pipelined RV32 core.
// Word RAM at address 0, plus a 16-byte register window at MMIO_BASE holding
// a free-running cycle counter, a TX byte FIFO push port, a FIFO status
// register and a scratch register.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   WE, RE, A, WD              store/load request, byte address, store data
//   RD                         combinational load data
//   Busy                       hold request: store to TXDATA while FIFO full
//   out_valid, out_data        FIFO head
//   out_ready                  consumer takes the head this cycle
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned RAM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic        RE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Busy,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready
);

   localparam int unsigned RamAw    = $clog2(RAM_WORDS);
   localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

   logic [31:0]      mem_q [RAM_WORDS];
   logic [31:0]      count_q, count_d;
   logic [31:0]      scratch_q, scratch_d;

   region_e          region;
   logic [31:0]      mmio_off;
   logic [3:0]       reg_off;
   logic [RamAw-1:0] ram_idx;
   logic             hit_ram, hit_count, hit_tx, hit_status, hit_scratch;
   logic             ram_we, tx_push;

   logic             fifo_full, fifo_empty;
   logic [CntW-1:0]  fifo_count;
   logic [7:0]       fifo_head;
   logic [31:0]      status;
   logic             unused_off;

   // Address decode
   assign region   = decode_region(A, RamBytes, MMIO_BASE);
   assign mmio_off = A - MMIO_BASE;
   assign reg_off  = {mmio_off[3:2], 2'b00};
   assign ram_idx  = A[RamAw+1:2];
   assign unused_off = ^{mmio_off[31:4], mmio_off[1:0]};

   assign hit_ram     = (region == REG_RAM);
   assign hit_count   = (region == REG_MMIO) && (reg_off == OFF_COUNT);
   assign hit_tx      = (region == REG_MMIO) && (reg_off == OFF_TXDATA);
   assign hit_status  = (region == REG_MMIO) && (reg_off == OFF_STATUS);
   assign hit_scratch = (region == REG_MMIO) && (reg_off == OFF_SCRATCH);

   // Busy uses the registered full flag, so a same-cycle pop on a full FIFO
   // only releases the core on the following cycle.
   assign Busy    = WE && hit_tx && fifo_full;
   assign tx_push = WE && hit_tx && !fifo_full;
   assign ram_we  = WE && hit_ram;

   always_comb begin
      status = '0;
      status[ST_FULL_BIT]  = fifo_full;
      status[ST_EMPTY_BIT] = fifo_empty;
      status[ST_OCC_LSB +: ST_OCC_W] = ST_OCC_W'(fifo_count);
   end

   // Load path: pre-write state, so a simultaneous store is not visible yet
   always_comb begin
      RD = '0;
      if (RE) begin
         if (hit_ram)          RD = mem_q[ram_idx];
         else if (hit_count)   RD = count_q;
         else if (hit_status)  RD = status;
         else if (hit_scratch) RD = scratch_q;
      end
   end

   always_comb begin
      count_d   = count_q + 32'd1;
      scratch_d = scratch_q;
      if (WE && hit_scratch) scratch_d = WD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         scratch_q <= '0;
      end else begin
         count_q   <= count_d;
         scratch_q <= scratch_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: 32'h0};
      end else if (ram_we) begin
         mem_q[ram_idx] <= WD;
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (tx_push),
      .data_i  (WD[7:0]),
      .pop_i   (out_ready),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, re, out_ready;
   logic [31:0] a, wd;
   logic [31:0] rd;
   logic        busy, out_valid;
   logic [7:0]  out_data;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_ram [256];
   logic [31:0] m_scratch;
   logic [31:0] m_count;
   logic [7:0]  m_q [$];

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .WE        (we),
      .RE        (re),
      .A         (a),
      .WD        (wd),
      .RD        (rd),
      .Busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   function automatic logic [31:0] exp_status();
      logic [3:0] occ;
      occ = 4'(m_q.size());
      return {24'h0, occ, 2'b00, m_q.size() == 0, m_q.size() == 8};
   endfunction

   function automatic logic [31:0] exp_rd(logic re_v, logic [31:0] a_v);
      if (!re_v) return 32'h0;
      if (a_v < 32'd1024) return m_ram[a_v[9:2]];
      if (a_v >= 32'h1000 && a_v < 32'h1010) begin
         case (a_v[3:2])
            2'd0: return m_count;
            2'd1: return 32'h0;
            2'd2: return exp_status();
            default: return m_scratch;
         endcase
      end
      return 32'h0;
   endfunction

   function automatic logic is_tx(logic [31:0] a_v);
      return a_v >= 32'h1004 && a_v < 32'h1008;
   endfunction

   task automatic drive(logic we_v, logic re_v, logic [31:0] a_v, logic [31:0] wd_v,
                        logic rdy_v);
      we = we_v; re = re_v; a = a_v; wd = wd_v; out_ready = rdy_v;
   endtask

   // Apply the current inputs to the model, then move to the next falling edge
   task automatic advance();
      logic full, pop, push;
      full = (m_q.size() == 8);
      pop  = (m_q.size() > 0) && out_ready;
      push = we && is_tx(a) && !full;
      if (we && a < 32'd1024) m_ram[a[9:2]] = wd;
      if (we && a >= 32'h100C && a < 32'h1010) m_scratch = wd;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(wd[7:0]);
      m_count = m_count + 32'd1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      foreach (m_ram[i]) m_ram[i] = 32'h0;
      m_scratch = 32'h0;
      m_count   = 32'h0;
      m_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] addrs [3];
      logic [31:0] exps [3];
      addrs = '{32'h0, 32'h1008, 32'h100C};
      exps  = '{32'h0, 32'h0000_0002, 32'h0};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, addrs[i], 32'h0, 1'b0);
         #1;
         total++;
         if (rd !== exps[i]) begin
            bad++; $display("FAIL reset_rd[%0d]: got %h want %h", i, rd, exps[i]);
         end
         #1;
      end
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_out: got v=%b busy=%b d=%h want 0 0 00", out_valid, busy, out_data);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h0) begin
         bad++; $display("FAIL reset_re0: got %h want 0", rd);
      end
   endtask

   task automatic test_ram();
      do_reset();
      drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      advance();
      drive(1'b0, 1'b1, 32'h12, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL ram_load: got %h want deadbeef", rd);
      end
      advance();
      drive(1'b1, 1'b0, 32'h2000, 32'h1234_5678, 1'b0);
      advance();
      drive(1'b0, 1'b1, 32'h2000, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h0) begin
         bad++; $display("FAIL unmapped_load: got %h want 0", rd);
      end
      advance();
      // Store and load together: RD shows the old word this cycle
      drive(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b0);
      #1;
      total++;
      if (rd !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL ram_rw_same: got %h want deadbeef", rd);
      end
      advance();
      drive(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL ram_rw_after: got %h want 0badf00d", rd);
      end
      advance();
      // Store to read-only COUNT/STATUS must not disturb anything
      drive(1'b1, 1'b0, 32'h1008, 32'hFFFF_FFFF, 1'b0);
      advance();
      drive(1'b0, 1'b1, 32'h1008, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h0000_0002) begin
         bad++; $display("FAIL status_ro: got %h want 00000002", rd);
      end
      advance();
   endtask

   task automatic test_fifo_full();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'h1004, 32'h41 + 32'(i), 1'b0);
         advance();
      end
      drive(1'b0, 1'b1, 32'h1008, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h81) begin
         bad++; $display("FAIL full_status: got %h want 00000081", rd);
      end
      drive(1'b1, 1'b0, 32'h1004, 32'h49, 1'b0);
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL busy_on_full: got %b want 1", busy);
      end
      advance();
      drive(1'b1, 1'b0, 32'h1004, 32'h49, 1'b1);
      #1;
      total++;
      if (busy !== 1'b1 || out_data !== 8'h41) begin
         bad++; $display("FAIL busy_pop_cycle: got busy=%b d=%h want 1 41", busy, out_data);
      end
      advance();
      drive(1'b1, 1'b0, 32'h1004, 32'h49, 1'b0);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL busy_release: got %b want 0", busy);
      end
      advance();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if (out_valid !== 1'b1 || out_data !== 8'(8'h42 + i)) begin
            bad++;
            $display("FAIL drain[%0d]: got v=%b d=%h want 1 %h", i, out_valid, out_data,
                     8'(8'h42 + i));
         end
         advance();
      end
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL drained_empty: got %b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h1004, 32'h10 + 32'(i), 1'b0);
         advance();
      end
      drive(1'b1, 1'b0, 32'h1004, 32'h13, 1'b1);
      #1;
      total++;
      if (out_data !== 8'h10) begin
         bad++; $display("FAIL pp_head_before: got %h want 10", out_data);
      end
      advance();
      drive(1'b0, 1'b1, 32'h1008, 32'h0, 1'b0);
      #1;
      total++;
      if (rd[7:4] !== 4'd3 || out_data !== 8'h11) begin
         bad++; $display("FAIL pp_after: got occ=%0d d=%h want 3 11", rd[7:4], out_data);
      end
      advance();
   endtask

   task automatic test_count();
      logic [31:0] c0, c1;
      do_reset();
      advance();
      advance();
      drive(1'b0, 1'b1, 32'h1000, 32'h0, 1'b0);
      #1;
      c0 = rd;
      total++;
      if (c0 !== m_count) begin
         bad++; $display("FAIL count_abs: got %h want %h", c0, m_count);
      end
      for (int i = 0; i < 5; i++) advance();
      #1;
      c1 = rd;
      total++;
      if (c1 - c0 !== 32'd5) begin
         bad++; $display("FAIL count_diff: got %0d want 5", c1 - c0);
      end
      // Store to COUNT is ignored
      drive(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
      advance();
      drive(1'b0, 1'b1, 32'h1000, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== m_count) begin
         bad++; $display("FAIL count_ro: got %h want %h", rd, m_count);
      end
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      total++;
      if (rd !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL count_forced: got %h want ffffffff", rd);
      end
      release dut.count_q;
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (rd !== 32'h0) begin
         bad++; $display("FAIL count_wrap: got %h want 0", rd);
      end
   endtask

   task automatic test_random();
      logic [31:0] ra, rwd, erd;
      logic        rwe, rre, rrdy, ebusy;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rwd  = $urandom;
         rwe  = 1'b0;
         rre  = $urandom_range(0, 1) == 1;
         rrdy = $urandom_range(0, 3) == 0;
         case ($urandom_range(0, 5))
            0: begin ra = {22'h0, 8'($urandom_range(0, 15)), 2'($urandom)}; rwe = 1'b1; end
            1: ra = {22'h0, 8'($urandom_range(0, 15)), 2'($urandom)};
            2: begin ra = 32'h1004 + 32'($urandom_range(0, 3)); rwe = 1'b1; end
            3: ra = 32'h1008;
            4: begin ra = 32'h100C; rwe = $urandom_range(0, 1) == 1; end
            default: begin
               ra = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h1010 + 32'($urandom_range(0, 64));
               rwe = $urandom_range(0, 1) == 1;
            end
         endcase
         drive(rwe, rre, ra, rwd, rrdy);
         erd   = exp_rd(rre, ra);
         ebusy = rwe && is_tx(ra) && (m_q.size() == 8);
         #1;
         total++;
         if (rd !== erd) begin
            bad++; $display("FAIL rand_rd[%0d]: a=%h got %h want %h", n, ra, rd, erd);
         end
         total++;
         if (busy !== ebusy) begin
            bad++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, ebusy);
         end
         total++;
         if (out_valid !== (m_q.size() != 0) ||
             out_data !== ((m_q.size() != 0) ? m_q[0] : 8'h00)) begin
            bad++;
            $display("FAIL rand_head[%0d]: got v=%b d=%h want v=%b", n, out_valid, out_data,
                     m_q.size() != 0);
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'h1004, 32'hA0 + 32'(i), 1'b0);
         advance();
      end
      drive(1'b1, 1'b0, 32'h100C, 32'h1234, 1'b0);
      advance();
      drive(1'b1, 1'b1, 32'h100C, 32'h5555, 1'b0);
      #1;
      total++;
      if (rd !== 32'h1234 || out_valid !== 1'b1) begin
         bad++; $display("FAIL pre_reset: got rd=%h v=%b want 1234 1", rd, out_valid);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: got v=%b busy=%b rd=%h want 0 0 0", out_valid, busy, rd);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b1, 32'h100C, 32'h0, 1'b0);
      #1;
      total++;
      if (rd !== 32'h0) begin
         bad++; $display("FAIL store_lost: got %h want 0", rd);
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      test_reset();
      test_ram();
      test_fifo_full();
      test_back_to_back();
      test_count();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
